// File: rtl/mmio_pkg.sv
// Shared constants for the batch MMIO shadow: register map, CTRL/STATUS bit
// positions, threshold reset values and the dispatch FSM states.
package mmio_pkg;

  localparam int TAG_W = 3;
  localparam int N_THR = 24;

  localparam logic [7:0] ADDR_STATUS = 8'h00;
  localparam logic [7:0] ADDR_CTRL   = 8'h01;
  localparam logic [7:0] ADDR_CH_EN  = 8'h02;
  localparam logic [7:0] ADDR_COUNT  = 8'h03;
  localparam logic [7:0] ADDR_RESULT = 8'h04;
  localparam logic [7:0] ADDR_TAG    = 8'h05;
  localparam logic [7:0] ADDR_THR_LO = 8'h10;
  localparam logic [7:0] ADDR_THR_HI = 8'h27;
  // upper five address bits of the T[c] / dT[c] windows (c = addr[2:0])
  localparam logic [4:0] ADDR_T_PAGE  = 5'b01000;
  localparam logic [4:0] ADDR_DT_PAGE = 5'b01001;

  localparam int CTRL_GO       = 0;
  localparam int CTRL_REG_MODE = 1;
  localparam int CTRL_DT_MODE  = 2;
  localparam int CTRL_INIT     = 3;
  localparam int CTRL_ABORT    = 4;
  localparam int CTRL_CLR_ERR  = 5;

  localparam int STAT_DONE  = 0;
  localparam int STAT_BUSY  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_FULL  = 3;
  localparam int STAT_OVF   = 4;
  localparam int STAT_TMO   = 5;

  // T set then dT set, each neg a..d, zero a..d, pos a..d
  localparam logic [0:N_THR-1][7:0] THR_RST = {
    8'h80, 8'h80, 8'hC0, 8'h00,  8'hC0, 8'h00, 8'h00, 8'h40,  8'h00, 8'h40, 8'h80, 8'h80,
    8'h80, 8'h80, 8'hC0, 8'h00,  8'hC0, 8'h00, 8'h00, 8'h40,  8'h00, 8'h40, 8'h80, 8'h80
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/result_fifo.sv
// Synchronous result FIFO. A push into a full FIFO is accepted only when a pop
// frees the head in the same cycle; the read port shows the head combinationally.
module result_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rp_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wp_q] = wdata;
    wp_d = do_push ? wp_q + 1'b1 : wp_q;
    rp_d = do_pop  ? rp_q + 1'b1 : rp_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/mmio_batch_if.sv
// MMIO register shadow for the fuzzy core: holds per-channel inputs and the
// threshold bank, runs the core over all enabled channels and queues tagged results.
module mmio_batch_if
  import mmio_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cs,
  input  logic         rd,
  input  logic         wr,
  input  logic [7:0]   addr,
  input  logic [7:0]   wdata,
  output logic [7:0]   rdata,
  output logic         start,
  output logic         init,
  output logic         reg_mode,
  output logic         dt_mode,
  output logic [7:0]   T_in,
  output logic [7:0]   dT_in,
  output logic [191:0] thr_flat,
  input  logic         valid,
  input  logic [7:0]   G_out
);

  localparam int         CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] CH_MASK = 8'((1 << N_CH) - 1);

  state_e                 state_q, state_d;
  logic [TAG_W-1:0]       ch_q, ch_d;
  logic [15:0]            tmo_cnt_q, tmo_cnt_d;
  logic                   done_q, done_d, ovf_q, ovf_d, tmo_err_q, tmo_err_d;
  logic                   start_q, start_d, init_q, init_d;
  logic                   reg_mode_q, reg_mode_d, dt_mode_q, dt_mode_d;
  logic [7:0]             t_in_q, t_in_d, dt_in_q, dt_in_d;
  logic [7:0]             ch_en_q, ch_en_d;
  logic [7:0]             t_q [8];
  logic [7:0]             t_d [8];
  logic [7:0]             dt_q [8];
  logic [7:0]             dt_d [8];
  logic [N_THR-1:0][7:0]  thr_q, thr_d;

  logic                   wr_en, rd_en, ctrl_wr, go, abort, clr_err, busy;
  logic [4:0]             thr_idx;
  logic                   first_vld, next_vld;
  logic [TAG_W-1:0]       first_ch, next_ch;
  logic                   push, pop;
  logic [TAG_W+7:0]       fifo_head;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full, fifo_empty;
  logic [7:0]             status;

  assign wr_en    = cs && wr;
  assign rd_en    = cs && rd;
  assign ctrl_wr  = wr_en && (addr == ADDR_CTRL);
  assign go       = ctrl_wr && wdata[CTRL_GO];
  assign abort    = ctrl_wr && wdata[CTRL_ABORT];
  assign clr_err  = ctrl_wr && wdata[CTRL_CLR_ERR];
  assign busy     = (state_q != ST_IDLE);
  assign thr_idx  = 5'(addr - ADDR_THR_LO);
  assign pop      = rd_en && (addr == ADDR_RESULT) && !fifo_empty;

  assign start    = start_q;
  assign init     = init_q;
  assign reg_mode = reg_mode_q;
  assign dt_mode  = dt_mode_q;
  assign T_in     = t_in_q;
  assign dT_in    = dt_in_q;
  assign thr_flat = thr_q;

  // lowest enabled channel overall, and lowest enabled channel above ch_q
  always_comb begin
    first_vld = 1'b0;
    first_ch  = '0;
    next_vld  = 1'b0;
    next_ch   = '0;
    for (int i = 7; i >= 0; i--) begin
      if (ch_en_q[i]) begin
        first_vld = 1'b1;
        first_ch  = TAG_W'(i);
      end
      if (ch_en_q[i] && (TAG_W'(i) > ch_q)) begin
        next_vld = 1'b1;
        next_ch  = TAG_W'(i);
      end
    end
  end

  always_comb begin
    t_d     = t_q;
    dt_d    = dt_q;
    thr_d   = thr_q;
    ch_en_d = ch_en_q;
    if (wr_en && (addr[7:3] == ADDR_T_PAGE)  && CH_MASK[addr[2:0]]) t_d[addr[2:0]]  = wdata;
    if (wr_en && (addr[7:3] == ADDR_DT_PAGE) && CH_MASK[addr[2:0]]) dt_d[addr[2:0]] = wdata;
    if (wr_en && (addr >= ADDR_THR_LO) && (addr <= ADDR_THR_HI)) thr_d[thr_idx] = wdata;
    if (wr_en && (addr == ADDR_CH_EN)) ch_en_d = wdata & CH_MASK;

    reg_mode_d = reg_mode_q;
    dt_mode_d  = dt_mode_q;
    if (ctrl_wr && !busy) begin
      reg_mode_d = wdata[CTRL_REG_MODE];
      dt_mode_d  = wdata[CTRL_DT_MODE];
    end
    init_d = ctrl_wr && wdata[CTRL_INIT];
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    tmo_cnt_d = tmo_cnt_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    tmo_err_d = tmo_err_q;
    t_in_d    = t_in_q;
    dt_in_d   = dt_in_q;
    push      = 1'b0;

    if (rd_en && (addr == ADDR_STATUS)) done_d = 1'b0;
    if (clr_err) begin
      ovf_d     = 1'b0;
      tmo_err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          if (first_vld) begin
            state_d = ST_ISSUE;
            ch_d    = first_ch;
            t_in_d  = t_q[first_ch];
            dt_in_d = dt_q[first_ch];
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (valid) begin
          state_d = ST_CAPTURE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
          if (tmo_cnt_d == 16'(TIMEOUT)) begin
            tmo_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_CAPTURE: begin
        push = 1'b1;
        if (next_vld) begin
          state_d = ST_ISSUE;
          ch_d    = next_ch;
          t_in_d  = t_q[next_ch];
          dt_in_d = dt_q[next_ch];
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      push    = 1'b0;
    end
    if (push && fifo_full && !pop) ovf_d = 1'b1;
    // start is simply "ISSUE next cycle", so an abort also suppresses it
    start_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      tmo_cnt_q  <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_err_q  <= 1'b0;
      start_q    <= 1'b0;
      init_q     <= 1'b0;
      reg_mode_q <= 1'b1;
      dt_mode_q  <= 1'b1;
      t_in_q     <= '0;
      dt_in_q    <= '0;
      ch_en_q    <= CH_MASK;
      t_q        <= '{default: '0};
      dt_q       <= '{default: '0};
      for (int i = 0; i < N_THR; i++) thr_q[i] <= THR_RST[i];
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      tmo_cnt_q  <= tmo_cnt_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      tmo_err_q  <= tmo_err_d;
      start_q    <= start_d;
      init_q     <= init_d;
      reg_mode_q <= reg_mode_d;
      dt_mode_q  <= dt_mode_d;
      t_in_q     <= t_in_d;
      dt_in_q    <= dt_in_d;
      ch_en_q    <= ch_en_d;
      t_q        <= t_d;
      dt_q       <= dt_d;
      thr_q      <= thr_d;
    end
  end

  result_fifo #(.W(TAG_W + 8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({ch_q, G_out}),
    .pop   (pop),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status             = '0;
    status[STAT_DONE]  = done_q;
    status[STAT_BUSY]  = busy;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_FULL]  = fifo_full;
    status[STAT_OVF]   = ovf_q;
    status[STAT_TMO]   = tmo_err_q;
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (addr)
        ADDR_STATUS: rdata = status;
        ADDR_CH_EN:  rdata = ch_en_q;
        ADDR_COUNT:  rdata = 8'(fifo_count);
        ADDR_RESULT: rdata = fifo_empty ? 8'h00 : fifo_head[7:0];
        ADDR_TAG:    rdata = fifo_empty ? 8'h00 : 8'(fifo_head[TAG_W+7:8]);
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: doc/mmio_batch_if.md
Name: mmio_batch_if

Overview:
Next-generation MCU register shadow for the fuzzy coprocessor core, on the same 8-bit MMIO bus.
- Holds N_CH independent (T, dT) channel inputs plus the shared 24-entry membership-threshold bank.
- A dispatch FSM runs the core once per enabled channel in one batch, without MCU involvement.
- Each G result, tagged with its channel index, goes into a result FIFO that the MCU pops.
- Adds a per-channel timeout, an overflow flag and abort, none of which the single-shot shadow had.

Parameters:
N_CH, 4, number of input channels (1..8)
FIFO_DEPTH, 8, result FIFO entries (power of two, 2..16)
TIMEOUT, 255, cycles to wait for valid after a start pulse before error (1..65535)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cs  in  1  bus chip select
rd  in  1  bus read strobe (one cycle per access)
wr  in  1  bus write strobe
addr  in  8  register address
wdata  in  8  write data
rdata  out  8  read data; combinational; 0 when !(cs&&rd)
start  out  1  one-cycle start pulse to core
init  out  1  one-cycle init pulse to core
reg_mode  out  1  rule-set select (1 = 9-rule)
dt_mode  out  1  1 = core uses internal dT
T_in  out  8  signed T of channel being processed
dT_in  out  8  signed dT of channel being processed
thr_flat  out  192  24 thresholds packed: index i at [8i+7:8i]; order T neg/zero/pos a..d, then dT neg/zero/pos a..d
valid  in  1  one-cycle DONE from core
G_out  in  8  core result; stable from the cycle after valid

Behaviour:
Reset (rst high at posedge):
- Outputs: reg_mode=1, dt_mode=1, start=0, init=0, T_in=0, dT_in=0.
- Channel regs = 0; CH_EN = all enabled channels set.
- Thresholds: T and dT sets are identical: neg 80,80,C0,00; zero C0,00,00,40; pos 00,40,80,80.
- FIFO empty; all sticky bits 0; FSM in IDLE.
- Reset mid-batch is clean: no pulse emitted, no push.

Register map:
- 0x00 STATUS, RO: {2'b0, tmo_err, ovf, full, empty, busy, done}. Read clears done only.
- 0x01 CTRL, WO: [0] GO (W1P), [1] REG_MODE, [2] DT_MODE, [3] INIT (W1P), [4] ABORT (W1P), [5] CLR_ERR (W1P, clears ovf and tmo_err).
- 0x02 CH_EN, RW: bits >= N_CH read 0.
- 0x03 FIFO_COUNT, RO.
- 0x04 RESULT, RO: pops the head G.
- 0x05 RESULT_TAG, RO: channel index of the head, peek without pop.
- 0x10..0x27 thresholds, WO.
- 0x40+c T[c], WO; 0x48+c dT[c], WO. Addresses for c >= N_CH are no-ops.
- Unmapped reads return 0.

INIT and CTRL write timing:
- init goes high the cycle after the write.
- REG_MODE and DT_MODE writes are ignored while busy.

FSM states: IDLE, ISSUE, WAIT, CAPTURE, DONE.
- IDLE: when GO is written, ch = lowest enabled index and go to ISSUE (start is high the cycle after the write). If CH_EN==0, set done and stay IDLE.
- ISSUE: start=1 for exactly one cycle; T_in/dT_in = T[ch]/dT[ch], held stable until leaving CAPTURE. Clear the timeout counter; go to WAIT.
- WAIT: a valid pulse moves to CAPTURE. When the counter reaches TIMEOUT, set tmo_err and go to IDLE with no push and done unchanged.
- CAPTURE (cycle after valid): push {ch, G_out}. Go to ISSUE for the next higher enabled channel, else to DONE.
- DONE: set done; go to IDLE.
- busy = (state != IDLE).
- ABORT in any state: IDLE next cycle, no push, FIFO contents kept.
- GO while busy is ignored.
- valid outside WAIT is ignored.

FIFO:
- Entry width 3+8.
- Push while full: drop the entry, set ovf; the batch continues.
- Pop while empty: RESULT reads 0, no state change.
- Push and pop in the same cycle: count unchanged; the popped data is the old head.
- Pointers wrap modulo FIFO_DEPTH.
- full = (count == FIFO_DEPTH).

Decomposition:
- Package mmio_pkg holds:
  - register address constants
  - CTRL/STATUS bit positions
  - the 24 threshold reset defaults as a constant array
  - the FSM state enum
  - tag width = 3
- One sub-module, result_fifo: synchronous FIFO, parametrised width/depth, with push/pop/count/full/empty.

Test Plan:
- Reset, then read 0x00 -> 0x04 (empty). Read 0x03 -> 0. Check thr_flat[7:0]=80 and thr_flat[191:184]=80.
- T[0..3]=10,20,30,40; CH_EN=0x0F; GO. Core model answers valid 5 cycles after each start with G=T+1 -> 4 start pulses. Then pops of 0x05/0x04 give (0,11),(1,21),(2,31),(3,41); done set, cleared by a STATUS read.
- CH_EN=0x05, GO -> starts only for ch0 and ch2; FIFO_COUNT=2.
- FIFO_DEPTH=2 build, 3 channels enabled -> count=2, ovf=1, entries are ch0 and ch1. CLR_ERR -> ovf=0.
- Core never asserts valid -> tmo_err set TIMEOUT cycles after start; busy=0; done=0; no push.
- ABORT written during WAIT -> busy=0 next cycle; a late valid does not push. GO written while busy produces no extra start.
